// File: rtl/flip_flop_fifo_with_level.sv
// flip_flop_fifo_with_level: flip-flop FIFO with exact occupancy, almost thresholds, flush and sticky errors
// Ports: clk, rst_n (async, active-low); push/pop/flush/clear_err requests; write_data in, read_data out
// (head entry); empty/full/almost_empty/almost_full decoded from the registered level; overflow/underflow sticky.
module flip_flop_fifo_with_level #(
    parameter int width            = 8,
    parameter int depth            = 10,
    parameter int almost_full_thr  = depth - 2,
    parameter int almost_empty_thr = 2,
    localparam int lw              = $clog2(depth + 1),
    localparam int pw              = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             clear_err,
    input  logic [width-1:0] write_data,
    output logic [width-1:0] read_data,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [lw-1:0]    level,
    output logic             overflow,
    output logic             underflow
);
    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;
    assign empty        = level == '0;
    assign full         = level == lw'(depth);
    assign almost_empty = level <= lw'(almost_empty_thr);
    assign almost_full  = level >= lw'(almost_full_thr);
    assign read_data    = mem[rd_ptr];
    // A push into a full FIFO is fine when a pop frees the slot it overwrites.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    always_ff @(posedge clk)
        if (push_ok && !flush) mem[wr_ptr] <= write_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr == pw'(depth - 1) ? '0 : wr_ptr + pw'(1);
                if (pop_ok)  rd_ptr <= rd_ptr == pw'(depth - 1) ? '0 : rd_ptr + pw'(1);
                level <= push_ok && !pop_ok ? level + lw'(1) :
                         pop_ok && !push_ok ? level - lw'(1) : level;
            end
            // A new error in the same cycle as clear_err wins; flush suppresses new errors.
            overflow  <= (push & ~push_ok & ~flush) | (overflow & ~clear_err);
            underflow <= (pop & ~pop_ok & ~flush) | (underflow & ~clear_err);
        end
    end
endmodule

// File: doc/flip_flop_fifo_with_level.md
# flip_flop_fifo_with_level

Parametrised flip-flop FIFO with an exact occupancy output, programmable almost-full/almost-empty thresholds, a synchronous flush and sticky overflow/underflow error flags. It is the successor to our plain counterless flip-flop FIFO. It is intended for shallow buffering between pipeline stages where the producer and consumer need early back-pressure and diagnosable misuse. Depth need not be a power of two.

## Interface

- `width`, 8, data word width in bits (≥1).
- `depth`, 10, number of entries (≥2, any integer).
- `almost_full_thr`, depth-2, `almost_full` asserts when level ≥ this value (1..depth).
- `almost_empty_thr`, 2, `almost_empty` asserts when level ≤ this value (0..depth-1).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `flush`  in  1  synchronous discard of all contents.
- `clear_err`  in  1  synchronous clear of sticky error flags.
- `write_data`  in  width  data to write.
- `read_data`  out  width  head entry, combinational from storage.
- `empty`  out  1  level == 0.
- `full`  out  1  level == depth.
- `almost_empty`  out  1  level ≤ almost_empty_thr.
- `almost_full`  out  1  level ≥ almost_full_thr.
- `level`  out  $clog2(depth+1)  current entry count, 0..depth.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.

## Operation

- Storage: `depth` flip-flop registers, no reset on data. Write and read pointers wrap from depth-1 to 0. Wrap is explicit and must not rely on power-of-two overflow.
- `level` is a registered counter. `empty`, `full`, `almost_*` are decoded from `level` only.
- Effective accept signals:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
- Pop on empty: rejected, including when a push arrives in the same cycle. There is no fall-through; the push is accepted alone.
- Push on full: rejected unless a pop arrives in the same cycle, in which case both are accepted and level is unchanged.
- Level update: +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither.
- Error flags:
  - `overflow` sets on push & ~push_ok.
  - `underflow` sets on pop & ~pop_ok.
  - Both hold until `clear_err` or reset.
  - If `clear_err` and a new error occur in the same cycle, the set wins.
- `flush` has priority over push/pop in the same cycle:
  - Both pointers and level go to 0.
  - The push is dropped and no data is written.
  - No error flag is set for that cycle's push/pop.
  - Error flags are not cleared by `flush`.
- `read_data` = storage[rd_ptr]. Its value is don't-care while `empty`; the bench must not check it then.

## Timing

- Reset (rst_n low, asynchronous):
  - Pointers = 0, level = 0.
  - empty = 1, full = 0.
  - almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
- Leaving reset is synchronous to the next rising clk; a push in the first cycle after rst_n rises is accepted.
- Push at edge N: level and flags reflect it after edge N. `read_data` shows that word after edge N if the FIFO was empty, so write-to-read latency is one cycle.
- Pop at edge N: `read_data` shows the next entry after edge N.
- All outputs except `read_data` are pure functions of registers, with no combinational path from inputs.
- `read_data` depends only on rd_ptr and storage, with no path from push/pop/write_data.
- Reset asserted mid-operation discards all contents and errors immediately, without waiting for a clock edge.

## Test plan

- **Fill to full.** After reset, push 0x01..0x0A (depth=10) on consecutive cycles. Expected:
  - level steps 1..10.
  - almost_full rises at level 8.
  - full = 1 after the 10th edge.
  - An 11th push sets overflow, and level stays 10.
- **Drain with wrap.** Pop 10 times, then push 0x11..0x15 and pop them. Expected:
  - read_data sequence 0x01..0x0A, then 0x11..0x15 across the pointer wrap.
  - empty = 1 at end.
  - almost_empty is 1 whenever level ≤ 2.
- **Simultaneous push/pop at the boundaries.**
  - At full, push 0xAA with a pop: level stays 10, overflow stays 0, and 0xAA is read last.
  - At empty, push with a pop: level becomes 1, underflow = 1, read_data = pushed word.
- **Flush.** With level 5, assert flush together with push 0x55. Expected:
  - level 0 and empty = 1 next cycle.
  - The following push 0x66 is read back first.
  - Existing overflow/underflow are retained.
- **Error clear and asynchronous reset.**
  - clear_err clears both flags.
  - clear_err coincident with a pop on empty leaves underflow = 1.
  - Dropping rst_n between edges at level 3 forces empty = 1 and level = 0 before the next clk edge.
